// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode constants,
// datapath widths, FSM state type and the illegal-opcode check.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CC_W   = 4;
  localparam int unsigned CNT_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND = 4'b0101;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0110;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0111;
  localparam logic [OP_W-1:0] OP_MUL = 4'b1111;

  // Flags reported for an illegal opcode: {N,Z,C,V} with only Z set
  localparam logic [CC_W-1:0] CC_ILLEGAL = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Opcodes with no ALU meaning; these complete with an error response
  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return (op == 4'b0000) || (op == 4'b0011) ||
           (op == 4'b0100) || (op == 4'b1010);
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Two-input grant selector.
// Ports:
//   valid0, valid1 : request valids
//   prio           : preferred requester when both are valid (0 for fixed priority)
//   grant_c        : some requester can be granted (combinational)
//   grant_id_c     : index of the requester that wins (combinational)
module alu_arb_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic grant_c,
  output logic grant_id_c
);

  // Contention resolves to prio; otherwise the only valid requester wins
  always_comb begin
    grant_c    = valid0 | valid1;
    grant_id_c = (valid0 && valid1) ? prio : valid1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU, holds the
// operands for a fixed number of execute cycles and returns the registered
// result through a valid/ready response channel.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration;
// without it requester 0 always wins.
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   reqN_valid/ready/aluop/a/b    : request channels (ready is the grant pulse)
//   alu_valA/valB/aluop/sub       : registered operands to the shared ALU
//   alu_result, alu_cc            : ALU result and {N,Z,C,V}
//   rsp_valid/ready/id/result/cc/err : response channel
// Parameter MUL_CYCLES (1-8): execute cycles for OP_MUL.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req0_aluop,
  input  logic [OP_W-1:0]   req1_aluop,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_valA,
  output logic [DATA_W-1:0] alu_valB,
  output logic [OP_W-1:0]   alu_aluop,
  output logic              alu_sub,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [CC_W-1:0]   alu_cc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [CC_W-1:0]   rsp_cc,
  output logic              rsp_err
);

  state_e              state_q;
  state_e              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;
  logic                take;
  logic                exec_done;
  logic                pick_grant_c;
  logic                pick_id_c;
  logic                prio;
  logic [OP_W-1:0]     op_sel;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;

`ifdef ALU_ARB_RR_EN
  logic rr_ptr_q;

  // Pointer names the preferred requester; after a grant it favours the other one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= 1'b0;
    end else if (take) begin
      rr_ptr_q <= ~pick_id_c;
    end
  end

  assign prio = rr_ptr_q;
`else
  assign prio = 1'b0;
`endif

  alu_arb_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .prio       (prio),
    .grant_c    (pick_grant_c),
    .grant_id_c (pick_id_c)
  );

  // Request fields of the winner; only consumed in the grant cycle
  assign op_sel = pick_id_c ? req1_aluop : req0_aluop;
  assign a_sel  = pick_id_c ? req1_a     : req0_a;
  assign b_sel  = pick_id_c ? req1_b     : req0_b;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and grant decode; ready is held off while reset is asserted
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    exec_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_grant_c && reset_n) begin
          take       = 1'b1;
          req0_ready = ~pick_id_c;
          req1_ready = pick_id_c;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          exec_done = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, execute counter and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_valA   <= '0;
      alu_valB   <= '0;
      alu_aluop  <= '0;
      alu_sub    <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cc     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (take) begin
        alu_valA  <= a_sel;
        alu_valB  <= b_sel;
        alu_aluop <= op_sel;
        alu_sub   <= (op_sel == OP_SUB);
        rsp_id    <= pick_id_c;
        err_q     <= is_illegal_op(op_sel);
        // Counter holds the number of execute cycles still to follow
        cnt_q     <= (op_sel == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
      end else if ((state_q == EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 3'd1;
      end

      if (exec_done) begin
        rsp_valid  <= 1'b1;
        rsp_result <= err_q ? '0 : alu_result;
        rsp_cc     <= err_q ? CC_ILLEGAL : alu_cc;
        rsp_err    <= err_q;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU model, a vector
// table for single operations and hand sequences for back-to-back grants,
// response back-pressure and reset during execute.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned MULC = 4;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_aluop, req1_aluop;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] alu_valA, alu_valB;
  logic [3:0]  alu_aluop;
  logic        alu_sub;
  logic [15:0] alu_result;
  logic [3:0]  alu_cc;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_cc;

  alu_arbiter #(.MUL_CYCLES(MULC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_aluop (req0_aluop),
    .req1_aluop (req1_aluop),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_valA   (alu_valA),
    .alu_valB   (alu_valB),
    .alu_aluop  (alu_aluop),
    .alu_sub    (alu_sub),
    .alu_result (alu_result),
    .alu_cc     (alu_cc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cc     (rsp_cc),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model: {result, N, Z, C, V}; unknown opcodes return junk
  function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB: begin
        r = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MUL:  r = a * b;
      default: r = a ^ ~b;
    endcase
    return {r, r[15], (r == 16'h0000), c, v};
  endfunction

  always_comb {alu_result, alu_cc} = alu_f(alu_aluop, alu_valA, alu_valB);

  typedef struct packed {
    logic        v0;
    logic        v1;
    logic [3:0]  op0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [3:0]  op1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        exp_id;
    logic [15:0] exp_res;
    logic [3:0]  exp_cc;
    logic        exp_err;
    logic [3:0]  exp_lat;
    logic [1:0]  hold;
  } vec_t;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic [3:0]  cc;
    logic        err;
  } exp_t;

  vec_t vecs [9];
  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no DUT event within the cycle budget", name);
  endtask

  task automatic check_rsp(input string tag, input exp_t e);
    check({tag, "_id"},     32'(rsp_id),     32'(e.id));
    check({tag, "_result"}, 32'(rsp_result), 32'(e.res));
    check({tag, "_cc"},     32'(rsp_cc),     32'(e.cc));
    check({tag, "_err"},    32'(rsp_err),    32'(e.err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
    check({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
    check({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    check({tag, "_rsp_id"},     32'(rsp_id),     32'd0);
    check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    check({tag, "_rsp_cc"},     32'(rsp_cc),     32'd0);
    check({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    check({tag, "_alu_valA"},   32'(alu_valA),   32'd0);
    check({tag, "_alu_valB"},   32'(alu_valB),   32'd0);
    check({tag, "_alu_aluop"},  32'(alu_aluop),  32'd0);
    check({tag, "_alu_sub"},    32'(alu_sub),    32'd0);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One table row: drive, expect a grant, check EXEC operands, latency and response
  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    exp_t        e;
    logic [3:0]  gop;
    logic [15:0] ga;
    logic [15:0] gb;
    @(negedge clk);
    req0_valid = v.v0;  req0_aluop = v.op0;  req0_a = v.a0;  req0_b = v.b0;
    req1_valid = v.v1;  req1_aluop = v.op1;  req1_a = v.a1;  req1_b = v.b1;
    rsp_ready  = (v.hold == 2'd0);
    #1;
    lat = 0;
    while (!(req0_ready || req1_ready) && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    if (!(req0_ready || req1_ready)) begin
      timeout_fail($sformatf("v%0d_grant_wait", idx));
      return;
    end
    check($sformatf("v%0d_grant", idx), 32'({req0_ready, req1_ready}),
          v.exp_id ? 32'd1 : 32'd2);
    gop = v.exp_id ? v.op1 : v.op0;
    ga  = v.exp_id ? v.a1  : v.a0;
    gb  = v.exp_id ? v.b1  : v.b0;
    e.id = v.exp_id;  e.res = v.exp_res;  e.cc = v.exp_cc;  e.err = v.exp_err;
    sb.push_back(e);

    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 16'($urandom);  req0_b = 16'($urandom);
    req1_a = 16'($urandom);  req1_b = 16'($urandom);
    req0_aluop = 4'($urandom); req1_aluop = 4'($urandom);
    #1;
    check($sformatf("v%0d_exec_aluop", idx), 32'(alu_aluop), 32'(gop));
    check($sformatf("v%0d_exec_valA", idx),  32'(alu_valA),  32'(ga));
    check($sformatf("v%0d_exec_valB", idx),  32'(alu_valB),  32'(gb));
    check($sformatf("v%0d_exec_sub", idx),   32'(alu_sub),   32'(gop == OP_SUB));

    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    if (!rsp_valid) begin
      timeout_fail($sformatf("v%0d_rsp_wait", idx));
      return;
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    e = sb.pop_front();
    check_rsp($sformatf("v%0d", idx), e);
    for (int k = 0; k < int'(v.hold); k++) begin
      @(negedge clk); #1;
      check($sformatf("v%0d_hold_valid", idx), 32'(rsp_valid), 32'd1);
      check_rsp($sformatf("v%0d_hold", idx), e);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check($sformatf("v%0d_rsp_done", idx), 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int   grants;
    int   cyc;
    int   last;
    logic eid;
    logic seen;
    exp_t e;

    //           v0    v1    op0      a0        b0        op1      a1        b1        id    res       cc     err   lat   hold
    vecs[0] = '{1'b1, 1'b0, OP_ADD,  16'h0003, 16'h0004, OP_ADD,  16'hDEAD, 16'hBEEF, 1'b0, 16'h0007, 4'h0, 1'b0, 4'd2, 2'd0};
    vecs[1] = '{1'b0, 1'b1, OP_SUB,  16'h1111, 16'h2222, OP_SUB,  16'h0005, 16'h0005, 1'b1, 16'h0000, 4'h4, 1'b0, 4'd2, 2'd0};
    vecs[2] = '{1'b1, 1'b0, 4'h3,    16'h0000, 16'h0000, OP_ADD,  16'hDEAD, 16'hBEEF, 1'b0, 16'h0000, 4'h4, 1'b1, 4'd2, 2'd0};
    vecs[3] = '{1'b0, 1'b1, OP_SUB,  16'h1111, 16'h2222, OP_ADD,  16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'h9, 1'b0, 4'd2, 2'd0};
    vecs[4] = '{1'b1, 1'b0, OP_ADD,  16'hFFFF, 16'h0001, OP_SUB,  16'hDEAD, 16'hBEEF, 1'b0, 16'h0000, 4'h6, 1'b0, 4'd2, 2'd0};
    vecs[5] = '{1'b0, 1'b1, OP_ADD,  16'h1111, 16'h2222, OP_SUB,  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 4'hA, 1'b0, 4'd2, 2'd0};
    vecs[6] = '{1'b0, 1'b1, OP_ADD,  16'h1111, 16'h2222, 4'hA,    16'h1234, 16'h5678, 1'b1, 16'h0000, 4'h4, 1'b1, 4'd2, 2'd0};
    vecs[7] = '{1'b1, 1'b0, OP_XOR,  16'hAAAA, 16'h5555, OP_ADD,  16'hDEAD, 16'hBEEF, 1'b0, 16'hFFFF, 4'h8, 1'b0, 4'd2, 2'd0};
    vecs[8] = '{1'b1, 1'b0, OP_MUL,  16'h0010, 16'h0003, OP_ADD,  16'hDEAD, 16'hBEEF, 1'b0, 16'h0030, 4'h0, 1'b0, 4'(1 + MULC), 2'd3};

    // Reset values, with a request already pending
    reset_n    = 1'b0;
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;  req0_aluop = OP_ADD;  req0_a = 16'h0001;  req0_b = 16'h0001;
    req1_valid = 1'b1;  req1_aluop = OP_SUB;  req1_a = 16'h0002;  req1_b = 16'h0001;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset_n    = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Both requesters valid continuously: grant order and 3-cycle spacing
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1;  req0_aluop = OP_ADD;  req0_a = 16'h0001;  req0_b = 16'h0001;
    req1_valid = 1'b1;  req1_aluop = OP_ADD;  req1_a = 16'h0002;  req1_b = 16'h0002;
    rsp_ready  = 1'b1;
    grants = 0;
    cyc    = 0;
    last   = 0;
    while ((grants < 4 || sb.size() != 0) && cyc < 60) begin
      if (grants == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          timeout_fail("cont_unexpected_rsp");
        end else begin
          e = sb.pop_front();
          check_rsp("cont", e);
        end
      end
      if (req0_ready || req1_ready) begin
`ifdef ALU_ARB_RR_EN
        eid = grants[0];
`else
        eid = 1'b0;
`endif
        check($sformatf("cont_grant%0d", grants), 32'({req0_ready, req1_ready}),
              eid ? 32'd1 : 32'd2);
        if (grants > 0) check($sformatf("cont_gap%0d", grants), 32'(cyc - last), 32'd3);
        last  = cyc;
        e.id  = eid;
        e.res = eid ? 16'h0004 : 16'h0002;
        e.cc  = 4'h0;
        e.err = 1'b0;
        sb.push_back(e);
        grants++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 60) timeout_fail("cont_budget");

    // Reset during EXEC aborts the operation
    @(negedge clk);
    req0_valid = 1'b1;  req0_aluop = OP_ADD;  req0_a = 16'h0101;  req0_b = 16'h0202;
    rsp_ready  = 1'b1;
    #1;
    check("rst_exec_grant", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("rst_exec_valA", 32'(alu_valA), 32'h0101);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_exec");
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_exec_no_rsp", 32'(seen), 32'd0);
    run_vec(9, vecs[0]);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
